// File: rtl/inst_fetch.sv
// Nibble fetch stage: one request at a time to program memory, PC-addressed, jump-aware.
// One cycle from MEM_ACK to D_VALID; D holds until D_READY, and MEM_RD stays up until MEM_ACK.
module inst_fetch (
  input  logic       CLK1,
  input  logic       RST_C,
  input  logic       RUN,
  input  logic       JMP,
  input  logic [7:0] JMP_ADDR,
  output logic [7:0] MEM_ADDR,
  output logic       MEM_RD,
  input  logic       MEM_ACK,
  input  logic [3:0] MEM_DATA,
  output logic [3:0] D,
  output logic       D_VALID,
  input  logic       D_READY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t     state, stateNxt;
  logic [7:0] pc, pcNxt;
  logic [7:0] jt, jtNxt;
  logic [3:0] dataReg, dataNxt;
  logic       dVld, dVldNxt;
  logic       memRd;

  always_ff @(posedge CLK1 or negedge RST_C) begin
    if (!RST_C) begin
      state   <= IDLE;
      pc      <= 8'h00;
      jt      <= 8'h00;
      dataReg <= 4'h0;
      dVld    <= 1'b0;
    end else begin
      state   <= stateNxt;
      pc      <= pcNxt;
      jt      <= jtNxt;
      dataReg <= dataNxt;
      dVld    <= dVldNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    pcNxt    = pc;
    jtNxt    = jt;
    dataNxt  = dataReg;
    dVldNxt  = dVld;
    memRd    = 1'b0;
    case (state)
      IDLE: begin
        if (JMP) pcNxt = JMP_ADDR;
        if (RUN) stateNxt = FETCH;
      end
      FETCH: begin
        memRd = 1'b1;
        if (JMP) begin
          jtNxt = JMP_ADDR;
          if (MEM_ACK) begin
            pcNxt    = JMP_ADDR;
            stateNxt = IDLE;
          end else begin
            stateNxt = FLUSH;
          end
        end else if (MEM_ACK) begin
          dataNxt  = MEM_DATA;
          pcNxt    = pc + 8'd1;
          dVldNxt  = 1'b1;
          stateNxt = HOLD;
        end
      end
      HOLD: begin
        // A jump drops the held nibble whether or not decode took it.
        if (JMP || D_READY) begin
          dVldNxt  = 1'b0;
          stateNxt = RUN ? FETCH : IDLE;
          if (JMP) pcNxt = JMP_ADDR;
        end
      end
      FLUSH: begin
        memRd = 1'b1;
        if (JMP) jtNxt = JMP_ADDR;
        if (MEM_ACK) begin
          pcNxt    = JMP ? JMP_ADDR : jt;
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign MEM_ADDR = pc;
  assign MEM_RD   = memRd;
  assign D        = dataReg;
  assign D_VALID  = dVld;

endmodule
